nv_nvdla_hls_rshift_sat_pipe: RTL and testbench



---
 rtl/nv_nvdla_hls_rshift_sat_pipe.sv | 164 ++++++++++++++++
 tb/tb_nv_nvdla_hls_rshift_sat_pipe.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nv_nvdla_hls_rshift_sat_pipe.sv
// Two-stage multi-lane rounding right shift followed by signed/unsigned saturation,
// with valid/ready flow control and a sticky, clamping count of saturated lanes.
module nv_nvdla_hls_rshift_sat_pipe #(
    parameter int IN_WIDTH    = 49,
    parameter int OUT_WIDTH   = 32,
    parameter int LANES       = 4,
    parameter int SHIFT_WIDTH = 6,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                           nvdla_core_clk,
    input  logic                           nvdla_core_rstn,
    input  logic                           in_pvld,
    output logic                           in_prdy,
    input  logic [LANES*IN_WIDTH-1:0]      in_pd,
    input  logic [SHIFT_WIDTH-1:0]         cfg_shift,
    input  logic                           cfg_unsigned,
    output logic                           out_pvld,
    input  logic                           out_prdy,
    output logic [LANES*OUT_WIDTH-1:0]     out_pd,
    output logic [LANES-1:0]               out_sat,
    input  logic                           sat_cnt_clr,
    output logic [CNT_WIDTH-1:0]           sat_cnt
);

    // One extra bit keeps x + 2^(s-1) from overflowing for any lane value.
    localparam int YW        = IN_WIDTH + 1;
    localparam int MAX_SHIFT = IN_WIDTH - 1;
    localparam int PW        = $clog2(LANES + 1);
    localparam logic signed [YW-1:0] SMAX = {{(YW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [YW-1:0] SMIN = {{(YW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic signed [YW-1:0] UMAX = {{(YW-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

    function automatic logic [PW-1:0] popcount(input logic [LANES-1:0] v);
        logic [PW-1:0] n;
        n = '0;
        for (int i = 0; i < LANES; i++) begin
            n = n + PW'(v[i]);
        end
        return n;
    endfunction

    logic                          s1_vld_r;
    logic                          s1_unsigned_r;
    logic signed [YW-1:0]          s1_y_r [LANES];
    logic                          out_pvld_r;
    logic [LANES*OUT_WIDTH-1:0]    out_pd_r;
    logic [LANES-1:0]              out_sat_r;
    logic [CNT_WIDTH-1:0]          sat_cnt_r;

    logic                          s1_rdy_s;
    logic                          s2_rdy_s;
    logic [31:0]                   eff_shift_s;
    logic signed [YW-1:0]          rnd_s;
    logic signed [IN_WIDTH-1:0]    x_s [LANES];
    logic signed [YW-1:0]          s1_y_s [LANES];
    logic [LANES*OUT_WIDTH-1:0]    sat_pd_s;
    logic [LANES-1:0]              sat_s;
    logic [CNT_WIDTH:0]            cnt_sum_s;

    // Backpressure chain: each stage may load when empty or when its content leaves.
    always_comb begin
        s2_rdy_s = !out_pvld_r || out_prdy;
        s1_rdy_s = !s1_vld_r || s2_rdy_s;
    end

    // Stage 1 datapath: clamp the shift amount, add the half-LSB, arithmetic shift.
    always_comb begin
        if (32'(cfg_shift) > 32'(MAX_SHIFT)) begin
            eff_shift_s = 32'(MAX_SHIFT);
        end else begin
            eff_shift_s = 32'(cfg_shift);
        end
        if (eff_shift_s != 32'd0) begin
            rnd_s = YW'(1'b1) << (eff_shift_s - 32'd1);
        end else begin
            rnd_s = '0;
        end
        for (int i = 0; i < LANES; i++) begin
            x_s[i]    = in_pd[i*IN_WIDTH +: IN_WIDTH];
            s1_y_s[i] = (YW'(x_s[i]) + rnd_s) >>> eff_shift_s;
        end
    end

    // Stage 1 registers: capture shifted lanes and clamp mode with the beat.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            s1_vld_r      <= 1'b0;
            s1_unsigned_r <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                s1_y_r[i] <= '0;
            end
        end else begin
            if (s1_rdy_s) begin
                s1_vld_r <= in_pvld;
            end
            if (s1_rdy_s && in_pvld) begin
                s1_unsigned_r <= cfg_unsigned;
                for (int i = 0; i < LANES; i++) begin
                    s1_y_r[i] <= s1_y_s[i];
                end
            end
        end
    end

    // Stage 2 datapath: saturate each lane to the selected output range.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            sat_pd_s[i*OUT_WIDTH +: OUT_WIDTH] = s1_y_r[i][OUT_WIDTH-1:0];
            sat_s[i] = 1'b0;
            if (s1_unsigned_r) begin
                if (s1_y_r[i][YW-1]) begin
                    sat_pd_s[i*OUT_WIDTH +: OUT_WIDTH] = {OUT_WIDTH{1'b0}};
                    sat_s[i] = 1'b1;
                end else if (s1_y_r[i] > UMAX) begin
                    sat_pd_s[i*OUT_WIDTH +: OUT_WIDTH] = {OUT_WIDTH{1'b1}};
                    sat_s[i] = 1'b1;
                end else begin
                    sat_s[i] = 1'b0;
                end
            end else begin
                if (s1_y_r[i] > SMAX) begin
                    sat_pd_s[i*OUT_WIDTH +: OUT_WIDTH] = {1'b0, {(OUT_WIDTH-1){1'b1}}};
                    sat_s[i] = 1'b1;
                end else if (s1_y_r[i] < SMIN) begin
                    sat_pd_s[i*OUT_WIDTH +: OUT_WIDTH] = {1'b1, {(OUT_WIDTH-1){1'b0}}};
                    sat_s[i] = 1'b1;
                end else begin
                    sat_s[i] = 1'b0;
                end
            end
        end
        cnt_sum_s = {1'b0, sat_cnt_r} + (CNT_WIDTH+1)'(popcount(sat_s));
    end

    // Stage 2 registers and the saturation counter; clear beats a same-cycle increment.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            out_pvld_r <= 1'b0;
            out_pd_r   <= '0;
            out_sat_r  <= '0;
            sat_cnt_r  <= '0;
        end else begin
            if (s2_rdy_s) begin
                out_pvld_r <= s1_vld_r;
            end
            if (s2_rdy_s && s1_vld_r) begin
                out_pd_r  <= sat_pd_s;
                out_sat_r <= sat_s;
            end
            if (sat_cnt_clr) begin
                sat_cnt_r <= '0;
            end else if (s2_rdy_s && s1_vld_r) begin
                sat_cnt_r <= cnt_sum_s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : cnt_sum_s[CNT_WIDTH-1:0];
            end
        end
    end

    assign in_prdy  = s1_rdy_s;
    assign out_pvld = out_pvld_r;
    assign out_pd   = out_pd_r;
    assign out_sat  = out_sat_r;
    assign sat_cnt  = sat_cnt_r;

endmodule

// File: tb/tb_nv_nvdla_hls_rshift_sat_pipe.sv
// Directed bench for the rshift/saturate pipe; a second copy with a 4-bit counter
// lets the counter clamp be reached in a handful of beats.
module tb_nv_nvdla_hls_rshift_sat_pipe;

    logic         clk;
    logic         rst_n;
    logic         in_pvld;
    logic         in_prdy;
    logic [195:0] in_pd;
    logic [5:0]   cfg_shift;
    logic         cfg_unsigned;
    logic         out_pvld;
    logic         out_prdy;
    logic [127:0] out_pd;
    logic [3:0]   out_sat;
    logic         sat_cnt_clr;
    logic [31:0]  sat_cnt;

    logic         sm_in_prdy;
    logic         sm_out_pvld;
    logic [127:0] sm_out_pd;
    logic [3:0]   sm_out_sat;
    logic [3:0]   sm_sat_cnt;

    int n_checks;
    int n_pass;

    nv_nvdla_hls_rshift_sat_pipe dut (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rst_n),
        .in_pvld(in_pvld), .in_prdy(in_prdy), .in_pd(in_pd),
        .cfg_shift(cfg_shift), .cfg_unsigned(cfg_unsigned),
        .out_pvld(out_pvld), .out_prdy(out_prdy), .out_pd(out_pd), .out_sat(out_sat),
        .sat_cnt_clr(sat_cnt_clr), .sat_cnt(sat_cnt)
    );

    nv_nvdla_hls_rshift_sat_pipe #(.CNT_WIDTH(4)) dut_small (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rst_n),
        .in_pvld(in_pvld), .in_prdy(sm_in_prdy), .in_pd(in_pd),
        .cfg_shift(cfg_shift), .cfg_unsigned(cfg_unsigned),
        .out_pvld(sm_out_pvld), .out_prdy(out_prdy), .out_pd(sm_out_pd), .out_sat(sm_out_sat),
        .sat_cnt_clr(sat_cnt_clr), .sat_cnt(sm_sat_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [195:0] pk_in(input logic [48:0] a, input logic [48:0] b,
                                           input logic [48:0] c, input logic [48:0] d);
        return {d, c, b, a};
    endfunction

    function automatic logic [127:0] pk_out(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

    // Beat k: lanes (k+1)<<k, (k+2)<<k, (k+3)<<k, -((k+1)<<k) shifted right by k.
    function automatic logic [195:0] bp_in(input int k);
        logic [48:0] v0, v1, v2, v3;
        v0 = 49'(k + 1) << k;
        v1 = 49'(k + 2) << k;
        v2 = 49'(k + 3) << k;
        v3 = 49'd0 - (49'(k + 1) << k);
        return pk_in(v0, v1, v2, v3);
    endfunction

    function automatic logic [127:0] bp_exp(input int k);
        return pk_out(32'(k + 1), 32'(k + 2), 32'(k + 3), 32'd0 - 32'(k + 1));
    endfunction

    // One beat through an empty pipe with out_prdy high; optional clear on its stage-2 load.
    task automatic run_beat(input string tag, input logic [195:0] pd, input logic [5:0] sh,
                            input logic uns, input logic clr, input logic [127:0] exp_pd,
                            input logic [3:0] exp_sat, input logic [31:0] exp_cnt,
                            input logic [3:0] exp_sm_cnt);
        int lat;
        in_pd = pd;
        cfg_shift = sh;
        cfg_unsigned = uns;
        in_pvld = 1'b1;
        #1;
        check_eq({tag, "_in_prdy"}, 128'(in_prdy), 128'd1);
        @(posedge clk);
        #1;
        in_pvld = 1'b0;
        sat_cnt_clr = clr;
        lat = 1;
        while (!out_pvld && lat < 6) begin
            @(posedge clk);
            #1;
            sat_cnt_clr = 1'b0;
            lat++;
        end
        sat_cnt_clr = 1'b0;
        check_eq({tag, "_latency"}, 128'(lat), 128'd2);
        check_eq({tag, "_pd"}, out_pd, exp_pd);
        check_eq({tag, "_sat"}, 128'(out_sat), 128'(exp_sat));
        check_eq({tag, "_cnt"}, 128'(sat_cnt), 128'(exp_cnt));
        check_eq({tag, "_cnt_small"}, 128'(sm_sat_cnt), 128'(exp_sm_cnt));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] held_pd;
        logic [3:0]   held_sat;
        logic         prev_hold;
        logic         in_acc;
        logic         out_acc;
        logic [195:0] all_sat;
        int sent;
        int got;
        int acc;
        int seen;
        int cyc;

        n_checks = 0;
        n_pass = 0;
        rst_n = 1'b0;
        in_pvld = 1'b0;
        in_pd = '0;
        cfg_shift = 6'd0;
        cfg_unsigned = 1'b0;
        out_prdy = 1'b1;
        sat_cnt_clr = 1'b0;
        #1;
        check_eq("rst_out_pvld", 128'(out_pvld), 128'd0);
        check_eq("rst_out_pd", out_pd, 128'd0);
        check_eq("rst_out_sat", 128'(out_sat), 128'd0);
        check_eq("rst_sat_cnt", 128'(sat_cnt), 128'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_eq("rst_in_prdy", 128'(in_prdy), 128'd1);
        @(posedge clk);
        #1;

        run_beat("signed_clamp",
                 pk_in(49'h100_0000_0000, 49'h1FF00_0000_0000, 49'd100, 49'h1_FFFF_FFFF_FFFF),
                 6'd0, 1'b0, 1'b0,
                 pk_out(32'h7FFF_FFFF, 32'h8000_0000, 32'd100, 32'hFFFF_FFFF),
                 4'b0011, 32'd2, 4'd2);
        run_beat("round_sh1",
                 pk_in(49'd3, 49'h1_FFFF_FFFF_FFFD, 49'd5, 49'h1_FFFF_FFFF_FFFB),
                 6'd1, 1'b0, 1'b0,
                 pk_out(32'd2, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFE),
                 4'b0000, 32'd2, 4'd2);
        run_beat("round_sh63",
                 pk_in(49'h0_FFFF_FFFF_FFFF, 49'h1_0000_0000_0000, 49'h0_8000_0000_0000, 49'd0),
                 6'd63, 1'b0, 1'b0,
                 pk_out(32'd1, 32'hFFFF_FFFF, 32'd1, 32'd0),
                 4'b0000, 32'd2, 4'd2);
        run_beat("unsigned",
                 pk_in(49'h1_FFFF_FFFF_FFFF, 49'h0_0002_0000_0000, 49'd7, 49'd0),
                 6'd0, 1'b1, 1'b0,
                 pk_out(32'd0, 32'hFFFF_FFFF, 32'd7, 32'd0),
                 4'b0011, 32'd4, 4'd4);
        run_beat("signed_edges",
                 pk_in(49'h7FFF_FFFF, 49'h8000_0000, 49'h1_FFFF_8000_0000, 49'h1_FFFF_7FFF_FFFF),
                 6'd0, 1'b0, 1'b0,
                 pk_out(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000),
                 4'b1010, 32'd6, 4'd6);
        run_beat("unsigned_edge",
                 pk_in(49'h0_FFFF_FFFF, 49'h1_0000_0000, 49'd0, 49'd1),
                 6'd0, 1'b1, 1'b0,
                 pk_out(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1),
                 4'b0010, 32'd7, 4'd7);

        all_sat = pk_in(49'h100_0000_0000, 49'h100_0000_0000, 49'h100_0000_0000, 49'h100_0000_0000);
        run_beat("clr_wins", all_sat, 6'd0, 1'b0, 1'b1,
                 pk_out(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF),
                 4'b1111, 32'd0, 4'd0);
        for (int k = 1; k <= 5; k++) begin
            run_beat("cnt_clamp", all_sat, 6'd0, 1'b0, 1'b0,
                     pk_out(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF),
                     4'b1111, 32'(4 * k), (k >= 4) ? 4'd15 : 4'(4 * k));
        end

        // Ten back-to-back beats, distinct shifts, random downstream stalls.
        sent = 0;
        got = 0;
        prev_hold = 1'b0;
        held_pd = '0;
        held_sat = '0;
        cyc = 0;
        while (got < 10 && cyc < 400) begin
            if (sent < 10) begin
                in_pvld = 1'b1;
                in_pd = bp_in(sent);
                cfg_shift = 6'(sent);
                cfg_unsigned = 1'b0;
            end else begin
                in_pvld = 1'b0;
            end
            out_prdy = 1'($urandom_range(0, 1));
            #1;
            if (prev_hold) begin
                check_eq("bp_stable_pd", out_pd, held_pd);
                check_eq("bp_stable_sat", 128'(out_sat), 128'(held_sat));
            end
            in_acc = in_pvld && in_prdy;
            out_acc = out_pvld && out_prdy;
            if (out_acc) begin
                check_eq($sformatf("bp_beat%0d", got), out_pd, bp_exp(got));
                got++;
            end
            prev_hold = out_pvld && !out_prdy;
            held_pd = out_pd;
            held_sat = out_sat;
            @(posedge clk);
            #1;
            if (in_acc) begin
                sent++;
            end
            cyc++;
        end
        in_pvld = 1'b0;
        out_prdy = 1'b1;
        check_eq("bp_count", 128'(got), 128'd10);
        check_eq("bp_cnt_unchanged", 128'(sat_cnt), 128'd20);
        @(posedge clk);
        #1;

        // Downstream stalled: exactly two beats fit before in_prdy drops.
        out_prdy = 1'b0;
        in_pvld = 1'b1;
        in_pd = bp_in(1);
        cfg_shift = 6'd1;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (in_prdy) begin
                acc++;
            end
            @(posedge clk);
            #1;
        end
        check_eq("stall_accepted", 128'(acc), 128'd2);
        check_eq("stall_in_prdy", 128'(in_prdy), 128'd0);
        check_eq("stall_out_pd", out_pd, bp_exp(1));
        in_pvld = 1'b0;
        out_prdy = 1'b1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (out_pvld) begin
                seen++;
            end
            @(posedge clk);
            #1;
        end
        check_eq("stall_drained", 128'(seen), 128'd2);

        // Reset with two beats held in the pipe.
        out_prdy = 1'b0;
        in_pvld = 1'b1;
        in_pd = all_sat;
        cfg_shift = 6'd0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        in_pvld = 1'b0;
        check_eq("midrst_full", 128'(out_pvld), 128'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_pvld", 128'(out_pvld), 128'd0);
        check_eq("midrst_out_pd", out_pd, 128'd0);
        check_eq("midrst_sat_cnt", 128'(sat_cnt), 128'd0);
        check_eq("midrst_in_prdy", 128'(in_prdy), 128'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_prdy = 1'b1;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (out_pvld) begin
                seen++;
            end
            @(posedge clk);
            #1;
        end
        check_eq("midrst_no_stale", 128'(seen), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
